// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: prescaled LED counter that runs up, down, bounce or hold.
// It also provides load, a tick strobe and a limit flag.
module led_counter_ctrl #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 2,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             at_limit
);
    localparam int TICK_CYCLES = CLK_FREQ / TICK_HZ;
    localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [PW-1:0]    r_pre;
    dir_t             r_dir;
    logic [WIDTH-1:0] w_next;
    dir_t             w_next_dir;
    logic             w_top;
    logic             w_bot;

    assign w_top    = leds == MAX;
    assign w_bot    = leds == '0;
    assign at_limit = w_top || w_bot;

    // Bounce reflects at a limit, so the limit value is shown for only one step.
    always_comb begin
        w_next     = leds;
        w_next_dir = r_dir;
        case (mode)
            2'b00: w_next = (w_top && !wrap_en) ? leds : leds + ONE;
            2'b01: w_next = (w_bot && !wrap_en) ? leds : leds - ONE;
            2'b10: begin
                w_next     = (r_dir == DIR_UP) ? (w_top ? MAX - ONE : leds + ONE)
                                               : (w_bot ? ONE : leds - ONE);
                w_next_dir = (r_dir == DIR_UP) ? (w_top ? DIR_DOWN : DIR_UP)
                                               : (w_bot ? DIR_UP : DIR_DOWN);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            leds  <= '0;
            tick  <= 1'b0;
            r_dir <= DIR_UP;
        end else if (load) begin
            r_pre <= '0;
            leds  <= load_value;
            tick  <= 1'b0;
            r_dir <= DIR_UP;
        end else if (!en) begin
            tick <= 1'b0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            tick  <= 1'b1;
            leds  <= w_next;
            r_dir <= w_next_dir;
        end else begin
            r_pre <= r_pre + 1'b1;
            tick  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb_led_counter_ctrl: directed and random stimulus.
// Outputs are checked against an integer reference model of the counter.
module tb_led_counter_ctrl;
    localparam int W    = 4;
    localparam int TC   = 5;
    localparam int MAXV = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic         wrap_en = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] leds;
    logic         tick;
    logic         at_limit;

    int n_pass  = 0;
    int n_total = 0;
    int m_pre   = 0;
    int m_leds  = 0;
    int m_dir   = 1;
    int m_tick  = 0;

    always #5 clk = ~clk;

    led_counter_ctrl #(.CLK_FREQ(10), .TICK_HZ(2), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .wrap_en(wrap_en),
        .load(load), .load_value(load_value),
        .leds(leds), .tick(tick), .at_limit(at_limit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".leds"}, 32'(leds), 32'(m_leds));
        chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
        chk({tag, ".at_limit"}, 32'(at_limit), 32'(m_leds == 0 || m_leds == MAXV));
    endtask

    // One clock: drive inputs, advance the reference model on the edge, then compare.
    task automatic cyc(input bit e, input bit l, input int lv, input int md, input bit wr);
        @(negedge clk);
        en = e; load = l; load_value = lv[W-1:0]; mode = md[1:0]; wrap_en = wr;
        @(posedge clk);
        if (l) begin
            m_leds = lv; m_pre = 0; m_dir = 1; m_tick = 0;
        end else if (!e) begin
            m_tick = 0;
        end else if (m_pre < TC - 1) begin
            m_pre++; m_tick = 0;
        end else begin
            m_pre = 0; m_tick = 1;
            case (md)
                0: m_leds = (m_leds + 1 > MAXV) ? (wr ? 0 : MAXV) : m_leds + 1;
                1: m_leds = (m_leds - 1 < 0) ? (wr ? MAXV : 0) : m_leds - 1;
                2: begin
                    if (m_leds + m_dir < 0 || m_leds + m_dir > MAXV) m_dir = -m_dir;
                    m_leds += m_dir;
                end
                default: ;
            endcase
        end
        #1 check_model("cyc");
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset.leds", 32'(leds), 0);
        chk("reset.tick", 32'(tick), 0);
        chk("reset.at_limit", 32'(at_limit), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (80) cyc(1, 0, 0, 0, 1);
        chk("up_wrap.leds", 32'(leds), 0);
        chk("up_wrap.at_limit", 32'(at_limit), 1);

        cyc(0, 1, 14, 0, 0);
        repeat (20) cyc(1, 0, 0, 0, 0);
        chk("sat_max.leds", 32'(leds), 15);
        cyc(0, 1, 1, 1, 0);
        repeat (15) cyc(1, 0, 0, 1, 0);
        chk("sat_min.leds", 32'(leds), 0);

        cyc(0, 1, 13, 2, 0);
        repeat (100) cyc(1, 0, 0, 2, 0);
        chk("bounce20.leds", 32'(leds), 3);

        cyc(0, 1, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);
        repeat (7) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("resume_wait.tick", 32'(tick), 0);
        cyc(1, 0, 0, 0, 1);
        chk("resume_step.tick", 32'(tick), 1);
        chk("resume_step.leds", 32'(leds), 1);

        for (int i = 0; i < TC && m_pre != TC - 1; i++) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 9, 0, 1);
        chk("load_tc.leds", 32'(leds), 9);
        chk("load_tc.tick", 32'(tick), 0);
        repeat (5) cyc(1, 0, 0, 0, 1);
        chk("load_next.leds", 32'(leds), 10);
        chk("load_next.tick", 32'(tick), 1);

        cyc(0, 1, 7, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 1);
        chk("pre_reset.leds", 32'(leds), 7);
        #1;
        en = 1'b0; load = 1'b0; rst_n = 1'b0;
        #1;
        chk("async_reset.leds", 32'(leds), 0);
        chk("async_reset.tick", 32'(tick), 0);
        chk("async_reset.at_limit", 32'(at_limit), 1);
        m_leds = 0; m_pre = 0; m_dir = 1; m_tick = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc(1, 0, 0, 0, 1);
        chk("restart.leds", 32'(leds), 1);
        chk("restart.tick", 32'(tick), 1);

        repeat (500) cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                         int'($urandom_range(0, MAXV)), int'($urandom_range(0, 3)),
                         $urandom_range(0, 1) == 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/led_counter_ctrl.md
Name: led_counter_ctrl

Overview:
Parametrised successor of the board LED counter. A prescaler divides the system clock down to a programmable tick rate, and a WIDTH-bit display counter steps once per tick. The counter runs up, down, bounce (ping-pong) or hold, and either wraps or saturates at the limits. The block adds enable, synchronous load, a tick strobe and a limit flag, and drives the LED bank directly from the top level.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
TICK_HZ, 2, counter steps per second; TICK_CYCLES = CLK_FREQ / TICK_HZ (integer division), must be >= 1
WIDTH, 8, display counter / LED width, must be >= 2

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = prescaler advances; 0 = prescaler and counter freeze
mode  in  2  00 up, 01 down, 10 bounce, 11 hold
wrap_en  in  1  1 = wrap at limits, 0 = saturate (up/down modes only)
load  in  1  synchronous load strobe
load_value  in  WIDTH  value loaded into the counter
leds  out  WIDTH  display counter value (registered)
tick  out  1  one-cycle pulse on each counter step slot (registered)
at_limit  out  1  combinational: leds == 0 or leds == MAX (MAX = 2^WIDTH-1)

Behaviour:
- Reset (rst_n low, asynchronous, any time incl. mid-count): prescaler=0, leds=0, tick=0, dir=up; at_limit=1 follows from leds=0.
- Priority per cycle: reset > load > en.
- load=1: leds<=load_value, prescaler<=0, dir<=up, tick<=0; en ignored that cycle.
- en=0, load=0: prescaler, leds and dir hold; tick<=0.
- en=1: prescaler increments 0..TICK_CYCLES-1. In the cycle where prescaler==TICK_CYCLES-1 it returns to 0, and on that same edge tick<=1 and leds take their next value. tick is 0 on every other cycle. With en held high, steps occur every TICK_CYCLES cycles; the first step after reset or load comes TICK_CYCLES edges later.
- Step rules, evaluated with the mode present on the step edge (mode changes between steps take effect at the next step):
  - up: leds<MAX gives +1. leds==MAX gives 0 if wrap_en, else stays MAX.
  - down: leds>0 gives -1. leds==0 gives MAX if wrap_en, else stays 0.
  - bounce (wrap_en ignored):
    - dir=up, leds<MAX: +1.
    - dir=up, leds==MAX: dir<=down, leds<=MAX-1.
    - dir=down, leds>0: -1.
    - dir=down, leds==0: dir<=up, leds<=1.
    - The limit value is therefore shown for exactly one step period.
  - hold: leds unchanged; tick still pulses; prescaler still runs.
- dir only changes in bounce mode or on load/reset. Leaving bounce and re-entering keeps the stored dir.
- All arithmetic is modulo 2^WIDTH. Prescaler width is sized for TICK_CYCLES-1, and it never exceeds TICK_CYCLES-1.

Test Plan:
1. CLK_FREQ=10, TICK_HZ=2 (5 cycles), WIDTH=4, en=1, mode=up, wrap_en=1, release reset -> tick high on edges 5, 10, 15…; leds 1, 2, 3…; after 16 steps leds=0 with at_limit=1.
2. Same config, wrap_en=0, load 14 then run up -> leds 15, 15, 15; tick keeps pulsing; at_limit=1 throughout saturation. Repeat with mode=down from load 1 -> 0, 0.
3. mode=bounce, load 13 -> leds 14, 15, 14, 13 … 1, 0, 1, 2; no value is repeated at either limit.
4. en toggled low for 7 cycles when prescaler=3 -> leds and tick frozen; after en returns, the next step occurs 2 cycles later.
5. load=1 in the same cycle the prescaler is at terminal count, load_value=9 -> leds=9, tick=0, next step 5 cycles later gives 10 in up mode.
6. rst_n asserted asynchronously between clock edges mid-count with leds=7 -> leds=0 and tick=0 immediately, before the next edge; counting restarts from prescaler=0 after release.
